// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if
//   Control and spike-stream bundle for lif_neuron_array.
//   master: drives step, current, reset_mode, thr_wr, thr_data;
//           observes busy, spike_valid, spike_idx, spikes, done.
//   slave : the neuron array (directions reversed).
//   Signals:
//     step        start one timestep scan (taken only when idle)
//     current     packed per-neuron input currents, neuron k at [k*WIDTH +: WIDTH]
//     reset_mode  0 = subtract threshold on spike, 1 = reset membrane to zero
//     thr_wr      threshold write strobe (taken only when idle)
//     thr_data    new threshold value
//     busy        scan in progress
//     spike_valid a neuron fired on the previous update cycle
//     spike_idx   index of that neuron
//     spikes      spike vector of the current/last step
//     done        one-cycle pulse at end of scan
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int IDXW      = $clog2(N_NEURONS)
) ();
  logic                       step;
  logic [N_NEURONS*WIDTH-1:0] current;
  logic                       reset_mode;
  logic                       thr_wr;
  logic [WIDTH-1:0]           thr_data;
  logic                       busy;
  logic                       spike_valid;
  logic [IDXW-1:0]            spike_idx;
  logic [N_NEURONS-1:0]       spikes;
  logic                       done;

  modport master (
    output step, current, reset_mode, thr_wr, thr_data,
    input  busy, spike_valid, spike_idx, spikes, done
  );

  modport slave (
    input  step, current, reset_mode, thr_wr, thr_data,
    output busy, spike_valid, spike_idx, spikes, done
  );
endinterface

// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   Time-multiplexed array of N leaky integrate-and-fire neurons sharing one
//   update datapath. A step scans neurons 0..N-1, one per cycle, applying
//   leak (U - (U >> LEAK_SHIFT)), saturating current integration and a
//   threshold compare with subtract or zero reset on firing.
//   Optional feature macro: LIF_REFRACTORY_EN (per-neuron refractory counter).
//   Ports:
//     clk           clock, rising edge
//     rst_n         synchronous active-low reset
//     bus           lif_neuron_array_if.slave (step/current/threshold in,
//                   busy/spike stream/spike vector/done out)
//     state_rd_idx  membrane read index
//     state_rd      membrane of neuron state_rd_idx (combinational read)
module lif_neuron_array #(
  parameter  int N_NEURONS    = 4,
  parameter  int WIDTH        = 8,
  parameter  int LEAK_SHIFT   = 2,
  parameter  int THRESH_INIT  = 230,
  parameter  int REFRAC_STEPS = 2,
  localparam int IDXW         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lif_neuron_array_if.slave    bus,
  input  logic [IDXW-1:0]      state_rd_idx,
  output logic [WIDTH-1:0]     state_rd
);

  if (N_NEURONS < 2 || REFRAC_STEPS < 0) begin : g_bad_cfg
    $error("lif_neuron_array: needs N_NEURONS >= 2 and REFRAC_STEPS >= 0");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem    [N_NEURONS];
  logic [WIDTH-1:0] cur_in [N_NEURONS];
  logic [WIDTH-1:0] cur_q  [N_NEURONS];
  logic [WIDTH-1:0] thr_q;
  logic             mode_q;
  logic [IDXW-1:0]  idx_q;

  logic [WIDTH-1:0] u_cur, decay, v, u_next;
  logic [WIDTH:0]   sum;
  logic             fire;

`ifdef LIF_REFRACTORY_EN
  localparam int RC_W = (REFRAC_STEPS < 2) ? 1 : $clog2(REFRAC_STEPS + 1);
  logic [RC_W-1:0] rc [N_NEURONS];
`endif

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_unpack
    assign cur_in[g] = bus.current[g*WIDTH +: WIDTH];
  end

  assign state_rd = (int'(state_rd_idx) < N_NEURONS) ? mem[state_rd_idx] : '0;

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.step) state_d = SCAN;
      end
      SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared update datapath for neuron idx_q. The sum is one bit wider so
  // overflow is detected and clamped instead of wrapping.
  always_comb begin
    u_cur  = mem[idx_q];
    decay  = u_cur - (u_cur >> LEAK_SHIFT);
    sum    = {1'b0, decay} + {1'b0, cur_q[idx_q]};
    v      = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    fire   = (v >= thr_q);
    u_next = fire ? (mode_q ? '0 : v - thr_q) : v;
`ifdef LIF_REFRACTORY_EN
    if (rc[idx_q] != '0) begin
      fire   = 1'b0;
      u_next = decay;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      thr_q           <= WIDTH'(THRESH_INIT);
      mode_q          <= 1'b0;
      bus.spike_valid <= 1'b0;
      bus.spike_idx   <= '0;
      bus.spikes      <= '0;
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        mem[k]   <= '0;
        cur_q[k] <= '0;
`ifdef LIF_REFRACTORY_EN
        rc[k]    <= '0;
`endif
      end
    end else begin
      state_q         <= state_d;
      bus.spike_valid <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.thr_wr) thr_q <= bus.thr_data;
        if (bus.step) begin
          cur_q      <= cur_in;
          mode_q     <= bus.reset_mode;
          idx_q      <= '0;
          bus.spikes <= '0;
        end
      end
      if (state_q == SCAN) begin
        mem[idx_q]        <= u_next;
        bus.spikes[idx_q] <= fire;
        bus.spike_valid   <= fire;
        bus.spike_idx     <= idx_q;
        idx_q             <= idx_q + 1'b1;
`ifdef LIF_REFRACTORY_EN
        if (rc[idx_q] != '0) rc[idx_q] <= rc[idx_q] - 1'b1;
        else if (fire)       rc[idx_q] <= RC_W'(REFRAC_STEPS);
`endif
      end
    end
  end

endmodule
